// File: rtl/histeq_phase_ctrl_if.sv
// Control bundle between the histogram-equalizer phase sequencer and its
// surroundings: frame start, per-stage go/done handshakes, m2 ownership,
// the clear-port write controls and frame status.
interface histeq_phase_ctrl_if;
    logic        start;
    logic        hist_done;
    logic        cdf_done;
    logic        remap_done;
    logic        hist_go;
    logic        cdf_go;
    logic        remap_go;
    logic [1:0]  m2_sel;
    logic [15:0] clr_addr;
    logic        clr_we;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_phase;

    // Host / stage side: drives start and the stage done flags.
    modport master (
        output start, hist_done, cdf_done, remap_done,
        input  hist_go, cdf_go, remap_go, m2_sel, clr_addr, clr_we,
               busy, done, err, err_phase
    );

    // Sequencer side.
    modport slave (
        input  start, hist_done, cdf_done, remap_done,
        output hist_go, cdf_go, remap_go, m2_sel, clr_addr, clr_we,
               busy, done, err, err_phase
    );
endinterface

// File: rtl/histeq_phase_ctrl.sv
// Phase sequencer for the histogram equalizer: clears scratchpad m2, then
// launches the histogram, CDF and remap stages in turn, handing m2 to the
// active stage and trapping a hung stage with a per-phase watchdog.
// All outputs are registered and decoded from the next state.
module histeq_phase_ctrl #(
    parameter int CLR_WORDS = 256,
    parameter int TIMEOUT   = 65535
) (
    input  logic               clock,
    input  logic               rst_n,
    histeq_phase_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_HIST_W, S_CDF_W, S_REMAP_W, S_DONE, S_ERR
    } state_t;

    // Last clear address and the watchdog value on which a phase expires;
    // with wd = 0 in the go cycle, the error appears TIMEOUT cycles after go.
    localparam logic [15:0] LAST_ADDR = 16'(CLR_WORDS - 1);
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] clr_addr_q, clr_addr_d;
    logic [15:0] wd_q, wd_d;
    logic        hist_go_q, hist_go_d;
    logic        cdf_go_q, cdf_go_d;
    logic        remap_go_q, remap_go_d;
    logic [1:0]  m2_sel_q, m2_sel_d;
    logic        clr_we_q, clr_we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_phase_q, err_phase_d;

    // Next state, then every registered output decoded from the next state.
    always_comb begin
        state_d     = state_q;
        err_phase_d = err_phase_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d     = S_CLEAR;
                    err_phase_d = 2'd0;
                end
            end
            S_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) state_d = S_HIST_W;
            end
            // A done seen in the go cycle may be stale from the last frame.
            S_HIST_W: begin
                if (bus.hist_done && !hist_go_q) begin
                    state_d = S_CDF_W;
                end else if (wd_q == WD_LAST) begin
                    state_d     = S_ERR;
                    err_phase_d = 2'd1;
                end
            end
            S_CDF_W: begin
                if (bus.cdf_done && !cdf_go_q) begin
                    state_d = S_REMAP_W;
                end else if (wd_q == WD_LAST) begin
                    state_d     = S_ERR;
                    err_phase_d = 2'd2;
                end
            end
            S_REMAP_W: begin
                if (bus.remap_done && !remap_go_q) begin
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    state_d     = S_ERR;
                    err_phase_d = 2'd3;
                end
            end
            default: state_d = S_IDLE;
        endcase

        clr_we_d   = (state_d == S_CLEAR);
        clr_addr_d = (state_q == S_CLEAR && state_d == S_CLEAR) ? clr_addr_q + 16'd1 : 16'd0;
        wd_d       = (state_d != state_q) ? 16'd0 : wd_q + 16'd1;
        hist_go_d  = (state_q == S_CLEAR)  && (state_d == S_HIST_W);
        cdf_go_d   = (state_q == S_HIST_W) && (state_d == S_CDF_W);
        remap_go_d = (state_q == S_CDF_W)  && (state_d == S_REMAP_W);
        case (state_d)
            S_HIST_W:  m2_sel_d = 2'd1;
            S_CDF_W:   m2_sel_d = 2'd2;
            S_REMAP_W: m2_sel_d = 2'd3;
            default:   m2_sel_d = 2'd0;
        endcase
        busy_d = (state_d == S_CLEAR) || (state_d == S_HIST_W) ||
                 (state_d == S_CDF_W) || (state_d == S_REMAP_W);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State, counters and outputs; reset aborts any frame immediately.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            clr_addr_q  <= 16'd0;
            wd_q        <= 16'd0;
            hist_go_q   <= 1'b0;
            cdf_go_q    <= 1'b0;
            remap_go_q  <= 1'b0;
            m2_sel_q    <= 2'd0;
            clr_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_phase_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            wd_q        <= wd_d;
            hist_go_q   <= hist_go_d;
            cdf_go_q    <= cdf_go_d;
            remap_go_q  <= remap_go_d;
            m2_sel_q    <= m2_sel_d;
            clr_we_q    <= clr_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_phase_q <= err_phase_d;
        end
    end

    assign bus.hist_go   = hist_go_q;
    assign bus.cdf_go    = cdf_go_q;
    assign bus.remap_go  = remap_go_q;
    assign bus.m2_sel    = m2_sel_q;
    assign bus.clr_addr  = clr_addr_q;
    assign bus.clr_we    = clr_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_phase = err_phase_q;
endmodule
